// File: rtl/digit_pkg.sv
// Shared key codes, blank code and controller state type for the keypad
// digit-entry sequencer.
package digit_pkg;

  localparam logic [3:0] KEY_BKSP = 4'hA;
  localparam logic [3:0] KEY_CLR  = 4'hB;
  localparam logic [3:0] KEY_ENT  = 4'hC;
  localparam logic [3:0] BLANK    = 4'hF;

  typedef enum logic [1:0] {
    INIT_CLR = 2'd0,
    IDLE     = 2'd1,
    REWRITE  = 2'd2
  } state_t;

  // Codes 0..9 are digits; everything above is a command or ignored.
  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/digit_entry_ctrl_idle_timer.sv
// Idle timer: counts enabled cycles and pulses expired_o combinationally
// in the cycle that completes TERMINAL enabled cycles. TERMINAL=0 disables it.
module idle_timer #(
  parameter int unsigned TERMINAL = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = (TERMINAL == 0) ? 1 : $clog2(TERMINAL + 1);
  localparam logic [W-1:0] LAST = W'((TERMINAL == 0) ? 0 : TERMINAL - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_last;

  assign at_last   = (TERMINAL != 0) && (cnt_q == LAST);
  assign expired_o = en_i && !clear_i && at_last;

  // Next count: clear wins, otherwise advance and wrap at the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || (TERMINAL == 0)) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_last ? '0 : cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/digit_entry_ctrl.sv
// Keypad-driven sequencer for a 4-digit shift-in display register.
// Keeps a shadow of the four stages (sa newest .. sd oldest) and emulates
// backspace/clear/timeout by pushing four complete new stage values.
//
// Handshake: key_valid is a one-cycle strobe with no back-pressure; a key
// seen while busy is high is discarded and reported by a key_drop pulse.
// seg_en is a one-cycle load strobe toward the shift register; seg_dec is
// meaningful only while seg_en is high.
module digit_entry_ctrl
  import digit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter bit          AUTO_CLEAR     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        seg_en,
  output logic [3:0]  seg_dec,
  output logic        busy,
  output logic [2:0]  count,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        key_drop,
  output logic        overflow
);

  state_t          state_q;
  logic [1:0]      idx_q;
  logic [3:0][3:0] pend_q;
  logic [3:0]      sa_q, sb_q, sc_q, sd_q;
  logic [2:0]      count_q;
  logic            seg_en_q;
  logic [3:0]      seg_dec_q;
  logic            busy_q;
  logic [15:0]     value_q;
  logic            value_valid_q;
  logic            key_drop_q;
  logic            overflow_q;

  logic            push_en;
  logic [3:0]      push_val;
  logic            rw_start;
  logic [3:0][3:0] rw_list;
  logic            tmr_en;
  logic            tmr_expired;

  assign seg_en      = seg_en_q;
  assign seg_dec     = seg_dec_q;
  assign busy        = busy_q;
  assign count       = count_q;
  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign key_drop    = key_drop_q;
  assign overflow    = overflow_q;

  // The timer only runs while digits sit untouched in IDLE; a key in the
  // same cycle as expiry holds it in clear, so the key always wins.
  assign tmr_en = (state_q == IDLE) && (count_q != 3'd0) && !key_valid;

  idle_timer #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (!tmr_en),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // Decide whether this cycle pushes a stage value and whether a rewrite
  // starts. Every rewrite list begins with a blank, so its first push is
  // issued in the same cycle the command is taken.
  always_comb begin
    push_en  = 1'b0;
    push_val = pend_q[idx_q];
    rw_start = 1'b0;
    rw_list  = {4{BLANK}};
    case (state_q)
      INIT_CLR: begin
        // Four pushes leave seg_en high with idx wrapped back to zero.
        push_en  = !(seg_en_q && (idx_q == 2'd0));
        push_val = BLANK;
      end
      REWRITE: begin
        push_en = (idx_q != 2'd0);
      end
      IDLE: begin
        if (key_valid) begin
          if (is_digit(key_code)) begin
            if (!count_q[2]) begin
              push_en  = 1'b1;
              push_val = key_code;
            end
          end else begin
            case (key_code)
              KEY_BKSP: begin
                if (count_q != 3'd0) begin
                  rw_start = 1'b1;
                  rw_list  = {sb_q, sc_q, sd_q, BLANK};
                end
              end
              KEY_CLR: rw_start = 1'b1;
              KEY_ENT: rw_start = (count_q != 3'd0) && AUTO_CLEAR;
              default: ;
            endcase
          end
        end else if (tmr_expired) begin
          rw_start = 1'b1;
        end
        if (rw_start) begin
          push_en  = 1'b1;
          push_val = BLANK;
        end
      end
      default: ;
    endcase
  end

  // Controller FSM with registered outputs and the shadow of the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= INIT_CLR;
      idx_q         <= 2'd0;
      pend_q        <= {4{BLANK}};
      sa_q          <= BLANK;
      sb_q          <= BLANK;
      sc_q          <= BLANK;
      sd_q          <= BLANK;
      count_q       <= 3'd0;
      seg_en_q      <= 1'b0;
      seg_dec_q     <= BLANK;
      busy_q        <= 1'b1;
      value_q       <= 16'h0000;
      value_valid_q <= 1'b0;
      key_drop_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      seg_en_q      <= push_en;
      value_valid_q <= 1'b0;
      key_drop_q    <= key_valid && (state_q != IDLE);
      overflow_q    <= 1'b0;
      if (push_en) begin
        seg_dec_q <= push_val;
        sd_q      <= sc_q;
        sc_q      <= sb_q;
        sb_q      <= sa_q;
        sa_q      <= push_val;
      end
      case (state_q)
        INIT_CLR, REWRITE: begin
          if (push_en) begin
            idx_q <= idx_q + 2'd1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (rw_start) begin
            state_q <= REWRITE;
            busy_q  <= 1'b1;
            idx_q   <= 2'd1;
            pend_q  <= rw_list;
          end
          if (key_valid) begin
            if (is_digit(key_code)) begin
              if (count_q[2]) overflow_q <= 1'b1;
              else            count_q    <= count_q + 3'd1;
            end else begin
              case (key_code)
                KEY_BKSP: if (count_q != 3'd0) count_q <= count_q - 3'd1;
                KEY_CLR:  count_q <= 3'd0;
                KEY_ENT: begin
                  if (count_q != 3'd0) begin
                    value_q       <= {sd_q, sc_q, sb_q, sa_q};
                    value_valid_q <= 1'b1;
                    if (AUTO_CLEAR) count_q <= 3'd0;
                  end
                end
                default: ;
              endcase
            end
          end else if (tmr_expired) begin
            count_q <= 3'd0;
          end
        end
        default: begin
          state_q <= INIT_CLR;
          idx_q   <= 2'd0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Self-checking bench for digit_entry_ctrl (TIMEOUT_CYCLES=8, AUTO_CLEAR=1).
module tb_digit_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        seg_en;
  logic [3:0]  seg_dec;
  logic        busy;
  logic [2:0]  count;
  logic [15:0] value;
  logic        value_valid;
  logic        key_drop;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  logic [3:0]  exp_q[$];
  logic [15:0] exp_val_q[$];
  logic [3:0]  mon_dec;
  logic [15:0] mon_val;

  typedef struct {
    logic [3:0]  code;
    int          n;
    logic [15:0] pushes;
    logic [2:0]  cnt;
    logic        ovf;
    logic        vv;
    logic [15:0] val;
  } vec_t;

  vec_t vecs[$];

  digit_entry_ctrl #(
    .TIMEOUT_CYCLES (8),
    .AUTO_CLEAR     (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .seg_en      (seg_en),
    .seg_dec     (seg_dec),
    .busy        (busy),
    .count       (count),
    .value       (value),
    .value_valid (value_valid),
    .key_drop    (key_drop),
    .overflow    (overflow)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] c, input int n, input logic [15:0] p,
                              input logic [2:0] cnt, input logic ovf, input logic vv,
                              input logic [15:0] val);
    vec_t v;
    v.code = c; v.n = n; v.pushes = p; v.cnt = cnt; v.ovf = ovf; v.vv = vv; v.val = val;
    return v;
  endfunction

  // Scoreboard monitor: every load strobe and value pulse is popped against
  // its expected queue just after the active edge.
  always @(posedge clk) begin
    #1;
    if (seg_en) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL seg_en_unexpected actual seg_dec=%0h required no push t=%0t", seg_dec, $time);
      end else begin
        mon_dec = exp_q.pop_front();
        chk("seg_dec", 32'(seg_dec), 32'(mon_dec));
      end
    end
    if (value_valid) begin
      if (exp_val_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL value_valid_unexpected actual value=%0h required no pulse t=%0t", value, $time);
      end else begin
        mon_val = exp_val_q.pop_front();
        chk("value", 32'(value), 32'(mon_val));
      end
    end
  end

  // Driver tasks: key_start raises the strobe at the next falling edge,
  // key_stop drops it one cycle later.
  task automatic key_start(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
  endtask

  task automatic key_stop();
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic key(input logic [3:0] c);
    key_start(c);
    key_stop();
  endtask

  task automatic push_blanks();
    for (int i = 0; i < 4; i++) exp_q.push_back(4'hF);
  endtask

  // Called right after reset release: four blank pushes, busy ends on cycle 5.
  task automatic wait_init();
    repeat (4) @(negedge clk);
    chk("init_busy_c4", 32'(busy), 32'd1);
    @(negedge clk);
    chk("init_busy_c5", 32'(busy), 32'd0);
    chk("init_count", 32'(count), 32'd0);
    chk("init_pushes_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_seg_en"}, 32'(seg_en), 32'd0);
    chk({tag, "_seg_dec"}, 32'(seg_dec), 32'hF);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_value"}, 32'(value), 32'd0);
    chk({tag, "_pulses"}, 32'({value_valid, key_drop, overflow}), 32'd0);
  endtask

  initial begin
    vec_t        v;
    logic [15:0] tmp;

    // Reset and power-up blanking.
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    push_blanks();
    rst = 1'b0;
    wait_init();

    // Single-key steps from IDLE.
    vecs.push_back(mk(4'h1, 1, 16'h1000, 3'd1, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'h2, 1, 16'h2000, 3'd2, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'h3, 1, 16'h3000, 3'd3, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'h4, 1, 16'h4000, 3'd4, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'h5, 0, 16'h0000, 3'd4, 1'b1, 1'b0, 16'h0000));
    vecs.push_back(mk(4'hE, 0, 16'h0000, 3'd4, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'hC, 4, 16'hFFFF, 3'd0, 1'b0, 1'b1, 16'h1234));
    vecs.push_back(mk(4'hA, 0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'hC, 0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'h1, 1, 16'h1000, 3'd1, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'h2, 1, 16'h2000, 3'd2, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'h3, 1, 16'h3000, 3'd3, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'h4, 1, 16'h4000, 3'd4, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'hA, 4, 16'hF123, 3'd3, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'h9, 1, 16'h9000, 3'd4, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'hC, 4, 16'hFFFF, 3'd0, 1'b0, 1'b1, 16'h1239));
    vecs.push_back(mk(4'h7, 1, 16'h7000, 3'd1, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'h8, 1, 16'h8000, 3'd2, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'hA, 4, 16'hFFF7, 3'd1, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'hC, 4, 16'hFFFF, 3'd0, 1'b0, 1'b1, 16'hFFF7));
    vecs.push_back(mk(4'h5, 1, 16'h5000, 3'd1, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'hB, 4, 16'hFFFF, 3'd0, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'hB, 4, 16'hFFFF, 3'd0, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'hF, 0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(4'hD, 0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000));

    for (int i = 0; i < vecs.size(); i++) begin
      v   = vecs[i];
      tmp = v.pushes;
      for (int j = 0; j < v.n; j++) begin
        exp_q.push_back(tmp[15:12]);
        tmp = tmp << 4;
      end
      if (v.vv) exp_val_q.push_back(v.val);
      key(v.code);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(v.cnt));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(v.ovf));
      chk($sformatf("vec%0d_busy", i), 32'(busy), (v.n == 4) ? 32'd1 : 32'd0);
      if (v.n == 4) begin
        repeat (4) @(negedge clk);
        chk($sformatf("vec%0d_busy_end", i), 32'(busy), 32'd0);
      end
      chk($sformatf("vec%0d_pushes_done", i), 32'(exp_q.size()), 32'd0);
    end

    // Keys during a rewrite are dropped; the first key at N+5 is taken.
    push_blanks();
    key_start(4'hB);
    key_stop();
    chk("drop_busy", 32'(busy), 32'd1);
    key_start(4'h5);
    key_stop();
    chk("drop_pulse1", 32'(key_drop), 32'd1);
    chk("drop_count", 32'(count), 32'd0);
    key_start(4'h6);
    exp_q.push_back(4'h7);
    key_start(4'h7);
    chk("drop_pulse2", 32'(key_drop), 32'd1);
    chk("drop_busy_n5", 32'(busy), 32'd0);
    key_stop();
    chk("after_drop_count", 32'(count), 32'd1);
    chk("after_drop_nodrop", 32'(key_drop), 32'd0);
    chk("after_drop_pushes", 32'(exp_q.size()), 32'd0);

    // Back-to-back digits on consecutive cycles.
    exp_q.push_back(4'h1); exp_q.push_back(4'h2); exp_q.push_back(4'h3);
    key_start(4'h1);
    key_start(4'h2);
    key_start(4'h3);
    key_stop();
    chk("b2b_count", 32'(count), 32'd4);
    chk("b2b_pushes", 32'(exp_q.size()), 32'd0);
    push_blanks();
    key(4'hB);
    repeat (4) @(negedge clk);
    chk("b2b_clear_count", 32'(count), 32'd0);

    // Idle timeout; a key in the expiry cycle pre-empts it.
    exp_q.push_back(4'h1);
    key(4'h1);
    repeat (6) @(negedge clk);
    exp_q.push_back(4'h2);
    key_start(4'h2);
    key_stop();
    chk("tmo_key_wins_count", 32'(count), 32'd2);
    chk("tmo_key_wins_busy", 32'(busy), 32'd0);
    repeat (7) @(negedge clk);
    chk("tmo_n8_busy", 32'(busy), 32'd0);
    chk("tmo_n8_count", 32'(count), 32'd2);
    push_blanks();
    @(negedge clk);
    chk("tmo_n9_busy", 32'(busy), 32'd1);
    chk("tmo_n9_count", 32'(count), 32'd0);
    repeat (4) @(negedge clk);
    chk("tmo_done_busy", 32'(busy), 32'd0);
    chk("tmo_pushes", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a rewrite.
    exp_q.push_back(4'h3); exp_q.push_back(4'h4);
    key(4'h3);
    key(4'h4);
    push_blanks();
    key_start(4'hB);
    key_stop();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    exp_q.delete();
    push_blanks();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_init();

    chk("values_all_seen", 32'(exp_val_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
